// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in, serial-out shifter.
// Accepts a width-bit word on a load/ready handshake and emits it LSB-first,
// one bit per clock, flagged by s_valid and with last on the final bit.
// Intended to feed a serial-in, right-shifting capture register directly.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   clr     - synchronous active-high reset, highest priority
//   din     - parallel word, sampled only on an accepted load
//   load    - load request, accepted when load && ready at an edge
//   ready   - block can accept a word this cycle
//   s_out   - serial data bit, LSB first
//   s_valid - s_out carries a frame bit this cycle
//   last    - current s_out bit is bit width-1 of the frame
//   busy    - frame in progress (same as s_valid)
module piso_shifter #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [width-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = (width <= 1) ? 1 : $clog2(width);
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Outputs come from registered state only.
    always_comb begin
        s_valid = (state_q == SHIFT);
        last    = s_valid && (cnt_q == CNT_LAST);
        ready   = !s_valid || last;
        s_out   = s_valid && sreg_q[0];
        busy    = s_valid;
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sreg_d  = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    // Final bit: either chain straight into the next frame
                    // (no gap bit) or drop back to idle with a clean sreg.
                    if (load) begin
                        sreg_d = din;
                        cnt_d  = '0;
                    end else begin
                        sreg_d  = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_shifter.sv
module tb_piso_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    // width=4 instance
    logic [3:0] din4;
    logic       load4, ready4, sout4, sv4, last4, busy4;
    // width=8 instance with loopback capture register
    logic [7:0] din8;
    logic       load8, ready8, sout8, sv8, last8, busy8;
    logic [7:0] cap;
    // width=1 instance
    logic [0:0] din1;
    logic       load1, ready1, sout1, sv1, last1, busy1;

    int checks = 0;
    int errors = 0;

    // Expected {bit, last} per valid cycle, one queue per instance.
    logic [1:0] q4[$];
    logic [1:0] q8[$];
    logic [1:0] q1[$];

    piso_shifter #(.width(4)) u4 (
        .clk(clk), .clr(clr), .din(din4), .load(load4), .ready(ready4),
        .s_out(sout4), .s_valid(sv4), .last(last4), .busy(busy4));
    piso_shifter #(.width(8)) u8 (
        .clk(clk), .clr(clr), .din(din8), .load(load8), .ready(ready8),
        .s_out(sout8), .s_valid(sv8), .last(last8), .busy(busy8));
    piso_shifter #(.width(1)) u1 (
        .clk(clk), .clr(clr), .din(din1), .load(load1), .ready(ready1),
        .s_out(sout1), .s_valid(sv1), .last(last1), .busy(busy1));

    // Serial-in right-shifting capture register fed by the width=8 instance.
    always @(posedge clk) begin
        if (sv8 === 1'b1) cap <= {sout8, cap[7:1]};
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [3:0] w, input int n);
        for (int i = 0; i < n; i++) q4.push_back({w[i], (i == 3) ? 1'b1 : 1'b0});
    endtask

    task automatic push8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q8.push_back({w[i], (i == 7) ? 1'b1 : 1'b0});
    endtask

    // Monitors: pop and compare on every valid cycle, away from the edge.
    always @(negedge clk) begin
        if (sv4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon4: unexpected valid bit %b", sout4);
            end else begin
                chk("mon4 {s_out,last}", {6'd0, sout4, last4}, {6'd0, q4.pop_front()});
            end
        end
        if (sv4 !== busy4) chk("mon4 busy", {7'd0, busy4}, {7'd0, sv4});
    end

    always @(negedge clk) begin
        if (sv8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon8: unexpected valid bit %b", sout8);
            end else begin
                chk("mon8 {s_out,last}", {6'd0, sout8, last8}, {6'd0, q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (sv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon1: unexpected valid bit %b", sout1);
            end else begin
                chk("mon1 {s_out,last}", {6'd0, sout1, last1}, {6'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        clr = 1'b1;
        load4 = 1'b1; din4 = 4'hF;
        load8 = 1'b1; din8 = 8'hFF;
        load1 = 1'b1; din1 = 1'b1;

        // Reset held two cycles with load asserted: nothing may start.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst s_valid", {7'd0, sv4}, 8'd0);
            chk("rst ready", {7'd0, ready4}, 8'd1);
            chk("rst s_out/last/busy", {5'd0, sout4, last4, busy4}, 8'd0);
            chk("rst w8/w1 s_valid", {6'd0, sv8, sv1}, 8'd0);
        end
        clr = 1'b0; load4 = 1'b0; load8 = 1'b0; load1 = 1'b0;
        step();
        chk("post-rst idle", {6'd0, sv4, ready4}, 8'd1);

        // Single frame 4'b1011 -> 1,1,0,1.
        load4 = 1'b1; din4 = 4'b1011; push4(4'b1011, 4);
        step();
        load4 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("single idle after", {6'd0, sv4, ready4}, 8'd1);

        // Back-to-back A then 5 with load held through the last cycle.
        load4 = 1'b1; din4 = 4'hA; push4(4'hA, 4);
        step();
        din4 = 4'h5; push4(4'h5, 4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b ready", {7'd0, ready4}, (i == 3) ? 8'd1 : 8'd0);
            step();
            chk("b2b contiguous", {7'd0, sv4}, 8'd1);
        end
        load4 = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("b2b last bit", {6'd0, sv4, last4}, 8'd3);
        step();
        chk("b2b idle", {7'd0, sv4}, 8'd0);

        // Ignored load of C during frame 3.
        load4 = 1'b1; din4 = 4'h3; push4(4'h3, 4);
        step();
        load4 = 1'b0;
        step();
        step();
        load4 = 1'b1; din4 = 4'hC;
        chk("ignored load ready", {7'd0, ready4}, 8'd0);
        step();
        load4 = 1'b0;
        step();
        step();
        chk("ignored idle", {7'd0, sv4}, 8'd0);
        step();
        chk("ignored no extra frame", {7'd0, sv4}, 8'd0);

        // Clear at bit 2 of F, then a fresh load of 1.
        load4 = 1'b1; din4 = 4'hF; push4(4'hF, 3);
        step();
        load4 = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
        chk("clr truncate", {4'd0, sv4, sout4, last4, ready4}, 8'h01);
        clr = 1'b0;
        load4 = 1'b1; din4 = 4'h1; push4(4'h1, 4);
        step();
        load4 = 1'b0;
        chk("clr reload starts", {7'd0, sv4}, 8'd1);
        for (int i = 0; i < 4; i++) step();
        chk("clr reload idle", {7'd0, sv4}, 8'd0);

        // Loopback at width 8: C3 then 5A back to back.
        load8 = 1'b1; din8 = 8'hC3; push8(8'hC3);
        step();
        din8 = 8'h5A; push8(8'h5A);
        for (int i = 0; i < 8; i++) step();
        load8 = 1'b0;
        chk("loopback cap C3", cap, 8'hC3);
        for (int i = 0; i < 8; i++) step();
        chk("loopback cap 5A", cap, 8'h5A);
        chk("loopback idle", {7'd0, sv8}, 8'd0);

        // Width 1 streaming 1,0,1.
        load1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din1 = (i == 1) ? 1'b0 : 1'b1;
            q1.push_back({din1[0], 1'b1});
            step();
            chk("w1 valid&last", {6'd0, sv1, last1}, 8'd3);
        end
        load1 = 1'b0;
        step();
        chk("w1 idle", {7'd0, sv1}, 8'd0);
        step();

        chk("q4 drained", 8'(q4.size()), 8'd0);
        chk("q8 drained", 8'(q8.size()), 8'd0);
        chk("q1 drained", 8'(q1.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shifter.md
# piso_shifter

Parallel-in, serial-out shifter: the transmit-side counterpart of the FFT datapath's serial-in, right-shifting capture register. It accepts a `width`-bit word on a load/ready handshake and emits it LSB-first, one bit per clock, with a valid and last-bit marker. Its `s_out` can drive the capture register's `s_in` directly, with `s_valid` gating the capture clock enable. After `width` valid cycles the capture register holds the original word.

## Interface
- `width`, default 4: word width in bits; must be ≥ 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `clr` input 1: reset; synchronous, active-high; highest priority.
- `din` input `width`: parallel word; sampled only on an accepted load.
- `load` input 1: load request; accepted when `load && ready` at a rising edge.
- `ready` output 1: block can accept a word this cycle.
- `s_out` output 1: serial data bit, LSB first.
- `s_valid` output 1: `s_out` carries a frame bit this cycle.
- `last` output 1: current `s_out` bit is bit `width-1` of the frame.
- `busy` output 1: frame in progress; equals `s_valid`.

## Operation
- Internal state:
  - `sreg[width-1:0]`: shift register.
  - `cnt`: bit counter, `max(1, $clog2(width))` bits.
  - One-bit state: IDLE or SHIFT.
- Reset (`clr`=1 at an edge): `sreg`=0, `cnt`=0, state=IDLE.
  - A `load` in the same cycle is ignored.
- IDLE:
  - `s_valid`=0, `s_out`=0, `last`=0, `ready`=1.
  - On an accepted load: `sreg`←`din`, `cnt`←0, go to SHIFT.
- SHIFT:
  - `s_valid`=1 and `s_out`=`sreg[0]`.
  - Each edge: `sreg`←{1'b0, `sreg[width-1:1]`} and `cnt`←`cnt`+1.
- Frame end:
  - `last`=1 when SHIFT and `cnt`==`width`-1.
  - `ready` = IDLE || `last`.
- Edge while `last`=1:
  - With an accepted load: `sreg`←`din`, `cnt`←0, stay in SHIFT. This gives back-to-back frames with no gap bit.
  - Without a load: go to IDLE, `sreg`←0.
- `load` while `ready`=0 is ignored; `din` is not sampled and the current frame is undisturbed.
- `width`=1: every SHIFT cycle has `last`=1; back-to-back loads stream one bit per clock.
- All outputs are decoded from registered state only; there are no combinational paths from `din` or `load`.

## Timing
- Load accepted at edge E:
  - Bit *i* of the word appears on `s_out` in the cycle after edge E+*i*, for *i* = 0…`width`-1.
  - Latency from load edge to first bit: one cycle.
- `last` is high for exactly one cycle per frame, on its final bit.
- Back-to-back throughput: one word per `width` cycles.
- `clr` asserted mid-frame:
  - The frame is truncated.
  - From the next cycle: `s_valid`=0, `s_out`=0, `last`=0, `ready`=1.
- After `clr` deasserts, the first load is accepted at the next edge.
- Reset values (cycle after a `clr` edge): `s_out`=0, `s_valid`=0, `last`=0, `busy`=0, `ready`=1.

## Test plan
- Reset:
  - Stimulus: hold `clr` 2 cycles with `load`=1, `din`=4'hF.
  - Required: `s_valid`=0, `ready`=1 throughout; no frame starts.
- Single frame:
  - Stimulus: `width`=4, load `din`=4'b1011.
  - Required: `s_out` = 1,1,0,1 over 4 cycles with `s_valid`=1; `last` high on the 4th cycle only; then IDLE.
- Back-to-back:
  - Stimulus: load 4'hA, then hold `load`=1 with `din`=4'h5 through the `last` cycle.
  - Required: 8 contiguous valid bits 0,1,0,1,1,0,1,0; a single `last` at bit 4 and at bit 8.
- Ignored load:
  - Stimulus: during frame 4'h3, pulse `load` with `din`=4'hC at bit 2.
  - Required: output stays 1,1,0,0; `ready`=0 at the pulse.
- Clear mid-frame:
  - Stimulus: assert `clr` at bit 2 of 4'hF.
  - Required: `s_valid`=0 from the next cycle; a new load of 4'h1 yields 1,0,0,0.
- Loopback:
  - Stimulus: `width`=8; drive a `width`=8 capture register with `s_in`=`s_out`, clocked only when `s_valid`; send 8'hC3, then 8'h5A.
  - Required: capture `dout`=8'hC3 after the first `last`, 8'h5A after the second.
  - Repeat with `width`=1, streaming bits 1,0,1: required `s_valid` and `last` stay high for 3 cycles.
